// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one right barrel shifter under round-robin grant.
// Define SHIFT_ARBITER_ROR_EN for two-pass rotate-right on op 11; otherwise op 11 runs as SRL.

module shift_right #(
    parameter int DATA_LENGTH = 32,
    localparam int SW = $clog2(DATA_LENGTH)
) (
    input  logic [DATA_LENGTH-1:0] data,
    input  logic [SW-1:0]          shamt,
    input  logic                   ir,
    output logic [DATA_LENGTH-1:0] result
);
    assign result = DATA_LENGTH'({{DATA_LENGTH{ir}}, data} >> shamt);
endmodule

module shift_arbiter #(
    parameter int DATA_LENGTH = 32,
    localparam int SW = $clog2(DATA_LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [1:0]             req0_op,
    input  logic [SW-1:0]          req0_shamt,
    input  logic [DATA_LENGTH-1:0] req0_data,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [1:0]             req1_op,
    input  logic [SW-1:0]          req1_shamt,
    input  logic [DATA_LENGTH-1:0] req1_data,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_id,
    output logic [DATA_LENGTH-1:0] resp_data,
    output logic [1:0]             state_dbg
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;

    // Handshake: a request transfers when reqN_valid && reqN_ready; a result
    // transfers when resp_valid && resp_ready. Unaccepted requests must hold still.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifdef SHIFT_ARBITER_ROR_EN
        PASS2 = 2'd1,
`endif
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic                   rr_ptr;
    logic                   accept, fire, grant;
    logic [1:0]             g_op;
    logic [SW-1:0]          g_shamt;
    logic [DATA_LENGTH-1:0] g_data;
    logic                   g_ror, in_pass2, rev_sel, sh_ir;
    logic [DATA_LENGTH-1:0] sh_src, sh_in, sh_out, sh_res;
    logic [SW-1:0]          sh_amt;

    function automatic logic [DATA_LENGTH-1:0] bit_rev(input logic [DATA_LENGTH-1:0] x);
        for (int i = 0; i < DATA_LENGTH; i++) bit_rev[i] = x[DATA_LENGTH-1-i];
    endfunction

    assign accept     = (state == IDLE) || (state == DONE && resp_ready);
    assign grant      = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    assign fire       = accept && (req0_valid || req1_valid);
    assign req0_ready = fire && !grant;
    assign req1_ready = fire && grant;
    assign state_dbg  = state;

    assign g_op    = grant ? req1_op    : req0_op;
    assign g_shamt = grant ? req1_shamt : req0_shamt;
    assign g_data  = grant ? req1_data  : req0_data;

`ifdef SHIFT_ARBITER_ROR_EN
    logic [DATA_LENGTH-1:0] ror_data, ror_t;
    logic [SW-1:0]          ror_shamt;
    logic                   ror_id;

    assign in_pass2 = (state == PASS2);
    assign g_ror    = (g_op == 2'b11);
    // Second pass is a left shift by (DL-n) mod DL, which the negation gives by width.
    assign sh_src   = in_pass2 ? ror_data : g_data;
    assign sh_amt   = in_pass2 ? -ror_shamt : g_shamt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ror_data  <= '0;
            ror_t     <= '0;
            ror_shamt <= '0;
            ror_id    <= 1'b0;
        end else if (fire && g_ror) begin
            ror_data  <= g_data;
            ror_t     <= sh_res;
            ror_shamt <= g_shamt;
            ror_id    <= grant;
        end
    end
`else
    assign in_pass2 = 1'b0;
    assign g_ror    = 1'b0;
    assign sh_src   = g_data;
    assign sh_amt   = g_shamt;
`endif

    // Left shifts reuse the right shifter by reversing operand and result.
    assign rev_sel = in_pass2 || (g_op == OP_SLL);
    assign sh_ir   = !in_pass2 && (g_op == OP_SRA) && g_data[DATA_LENGTH-1];
    assign sh_in   = rev_sel ? bit_rev(sh_src) : sh_src;
    assign sh_res  = rev_sel ? bit_rev(sh_out) : sh_out;

    shift_right #(.DATA_LENGTH(DATA_LENGTH)) u_shift_right (
        .data   (sh_in),
        .shamt  (sh_amt),
        .ir     (sh_ir),
        .result (sh_out)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (fire) begin
                    state_next = DONE;
`ifdef SHIFT_ARBITER_ROR_EN
                    if (g_ror) state_next = PASS2;
`endif
                end else if (state == DONE && resp_ready) begin
                    state_next = IDLE;
                end
            end
`ifdef SHIFT_ARBITER_ROR_EN
            PASS2: state_next = DONE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= (state_next == DONE);
            if (fire) rr_ptr <= ~grant;
            if (fire && !g_ror) begin
                resp_id   <= grant;
                resp_data <= sh_res;
            end
`ifdef SHIFT_ARBITER_ROR_EN
            if (in_pass2) begin
                resp_id   <= ror_id;
                resp_data <= ror_t | sh_res;
            end
`endif
        end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: single ops, round-robin streaming, stalls, resets,
// and rotate-right when SHIFT_ARBITER_ROR_EN is defined.

module tb_shift_arbiter;
    localparam int DL = 32;
    localparam int SW = 5;
    localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROR = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]    req0_op, req1_op;
    logic [SW-1:0] req0_shamt, req1_shamt;
    logic [DL-1:0] req0_data, req1_data;
    logic          resp_valid, resp_ready, resp_id;
    logic [DL-1:0] resp_data;
    logic [1:0]    state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    logic [DL:0] exp_q[$];
    logic [DL:0] exp_item;

    // Round-robin stream tables: op, shamt, operand, hand-computed result.
    localparam logic [1:0]    RR0_OP [4] = '{SRL, SRA, SLL, SRL};
    localparam logic [SW-1:0] RR0_SH [4] = '{5'd1, 5'd3, 5'd8, 5'd0};
    localparam logic [DL-1:0] RR0_D  [4] = '{32'h80000000, 32'h80000000, 32'h000000AB, 32'hDEADBEEF};
    localparam logic [DL-1:0] RR0_E  [4] = '{32'h40000000, 32'hF0000000, 32'h0000AB00, 32'hDEADBEEF};
    localparam logic [1:0]    RR1_OP [4] = '{SLL, SRA, SRL, SRA};
    localparam logic [SW-1:0] RR1_SH [4] = '{5'd1, 5'd2, 5'd31, 5'd31};
    localparam logic [DL-1:0] RR1_D  [4] = '{32'h00000001, 32'h40000000, 32'hFFFFFFFF, 32'h80000000};
    localparam logic [DL-1:0] RR1_E  [4] = '{32'h00000002, 32'h10000000, 32'h00000001, 32'hFFFFFFFF};

    shift_arbiter #(.DATA_LENGTH(DL)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_shamt(req0_shamt), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_shamt(req1_shamt), .req1_data(req1_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .state_dbg(state_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic idle_inputs();
        req0_valid = 1'b0; req0_op = SLL; req0_shamt = '0; req0_data = '0;
        req1_valid = 1'b0; req1_op = SLL; req1_shamt = '0; req1_data = '0;
        resp_ready = 1'b1;
    endtask

    task automatic drive(input int port, input logic [1:0] op, input logic [SW-1:0] sh,
                         input logic [DL-1:0] d);
        if (port == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_shamt = sh; req0_data = d;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_shamt = sh; req1_data = d;
        end
    endtask

    task automatic single_op(input string tag, input int port, input logic [1:0] op,
                             input logic [SW-1:0] sh, input logic [DL-1:0] d,
                             input logic [DL-1:0] exp);
        @(negedge clk);
        resp_ready = 1'b1;
        drive(port, op, sh, d);
        #1;
        check({tag, " rdy0"}, 64'(req0_ready), 64'(port == 0));
        check({tag, " rdy1"}, 64'(req1_ready), 64'(port == 1));
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check({tag, " valid"}, 64'(resp_valid), 64'd1);
        check({tag, " id"},    64'(resp_id),    64'(port));
        check({tag, " data"},  64'(resp_data),  64'(exp));
        check({tag, " state"}, 64'(state_dbg),  64'd2);
        @(negedge clk);
        #1;
        check({tag, " drained"}, 64'(resp_valid), 64'd0);
        check({tag, " idle"},    64'(state_dbg),  64'd0);
    endtask

`ifdef SHIFT_ARBITER_ROR_EN
    task automatic ror_op(input string tag, input logic [SW-1:0] sh, input logic [DL-1:0] d,
                          input logic [DL-1:0] exp);
        @(negedge clk);
        resp_ready = 1'b1;
        drive(0, ROR, sh, d);
        #1;
        check({tag, " rdy0"}, 64'(req0_ready), 64'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check({tag, " pass2 state"}, 64'(state_dbg),  64'd1);
        check({tag, " pass2 valid"}, 64'(resp_valid), 64'd0);
        @(negedge clk);
        #1;
        check({tag, " valid"}, 64'(resp_valid), 64'd1);
        check({tag, " data"},  64'(resp_data),  64'(exp));
        check({tag, " id"},    64'(resp_id),    64'd0);
        @(negedge clk);
        #1;
        check({tag, " drained"}, 64'(resp_valid), 64'd0);
    endtask
`endif

    task automatic rr_stream();
        int i0 = 0;
        int i1 = 0;
        int g;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            resp_ready = 1'b1;
            drive(0, RR0_OP[i0], RR0_SH[i0], RR0_D[i0]);
            drive(1, RR1_OP[i1], RR1_SH[i1], RR1_D[i1]);
            #1;
            check("rr resp_valid", 64'(resp_valid), 64'(k > 0));
            if (k > 0) begin
                exp_item = exp_q.pop_front();
                check("rr result", 64'({resp_id, resp_data}), 64'(exp_item));
            end
            g = k % 2;
            check("rr rdy0", 64'(req0_ready), 64'(g == 0));
            check("rr rdy1", 64'(req1_ready), 64'(g == 1));
            if (g == 0) begin
                exp_q.push_back({1'b0, RR0_E[i0]});
                i0++;
            end else begin
                exp_q.push_back({1'b1, RR1_E[i1]});
                i1++;
            end
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("rr last valid", 64'(resp_valid), 64'd1);
        exp_item = exp_q.pop_front();
        check("rr last result", 64'({resp_id, resp_data}), 64'(exp_item));
        @(negedge clk);
        #1;
        check("rr drained", 64'(resp_valid), 64'd0);
    endtask

    task automatic stall_test();
        @(negedge clk);
        resp_ready = 1'b0;
        drive(0, SRL, 5'd4, 32'h12345678);
        drive(1, SRA, 5'd4, 32'h80000000);
        #1;
        check("stall rdy0", 64'(req0_ready), 64'd1);
        check("stall rdy1", 64'(req1_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req0_valid = 1'b0;
            #1;
            check("stall valid", 64'(resp_valid), 64'd1);
            check("stall data",  64'(resp_data),  64'h01234567);
            check("stall id",    64'(resp_id),    64'd0);
            check("stall rdy",   64'({req0_ready, req1_ready}), 64'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        #1;
        check("release rdy1", 64'(req1_ready), 64'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check("release valid", 64'(resp_valid), 64'd1);
        check("release id",    64'(resp_id),    64'd1);
        check("release data",  64'(resp_data),  64'hF8000000);
        @(negedge clk);
        #1;
        check("release drained", 64'(resp_valid), 64'd0);
    endtask

    task automatic reset_in_done();
        @(negedge clk);
        resp_ready = 1'b0;
        drive(0, SRL, 5'd1, 32'h00000002);
        #1;
        check("rst done rdy0", 64'(req0_ready), 64'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("rst done pre state", 64'(state_dbg), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst done valid", 64'(resp_valid), 64'd0);
        check("rst done data",  64'(resp_data),  64'd0);
        check("rst done state", 64'(state_dbg),  64'd0);
        drive(0, SRL, 5'd4, 32'h80000000);
        drive(1, SRA, 5'd4, 32'h80000000);
        #1;
        check("rst done grant0", 64'({req0_ready, req1_ready}), 64'b10);
        @(negedge clk);
        idle_inputs();
        #1;
        check("rst done next id",   64'(resp_id),   64'd0);
        check("rst done next data", 64'(resp_data), 64'h08000000);
        @(negedge clk);
    endtask

`ifdef SHIFT_ARBITER_ROR_EN
    task automatic reset_in_pass2();
        @(negedge clk);
        resp_ready = 1'b1;
        drive(0, ROR, 5'd8, 32'h12345678);
        #1;
        check("rst p2 rdy0", 64'(req0_ready), 64'd1);
        @(negedge clk);
        drive(0, SRL, 5'd4, 32'h80000000);
        drive(1, SRA, 5'd4, 32'h80000000);
        #1;
        check("rst p2 state", 64'(state_dbg), 64'd1);
        check("rst p2 no accept", 64'({req0_ready, req1_ready}), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst p2 valid", 64'(resp_valid), 64'd0);
        check("rst p2 idle",  64'(state_dbg),  64'd0);
        check("rst p2 grant0", 64'({req0_ready, req1_ready}), 64'b10);
        @(negedge clk);
        idle_inputs();
        #1;
        check("rst p2 next id",   64'(resp_id),   64'd0);
        check("rst p2 next data", 64'(resp_data), 64'h08000000);
        @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("reset valid", 64'(resp_valid), 64'd0);
        check("reset id",    64'(resp_id),    64'd0);
        check("reset data",  64'(resp_data),  64'd0);
        check("reset state", 64'(state_dbg),  64'd0);
        check("reset rdy",   64'({req0_ready, req1_ready}), 64'd0);
        rst = 1'b0;

        single_op("srl",      0, SRL, 5'd4,  32'h80000000, 32'h08000000);
        single_op("sra neg",  1, SRA, 5'd4,  32'h80000000, 32'hF8000000);
        single_op("sll 31",   0, SLL, 5'd31, 32'h00000001, 32'h80000000);
        single_op("sra pos",  1, SRA, 5'd4,  32'h70000000, 32'h07000000);
        single_op("sll 4",    0, SLL, 5'd4,  32'h12345678, 32'h23456780);
        single_op("srl 0",    1, SRL, 5'd0,  32'hCAFEF00D, 32'hCAFEF00D);
`ifdef SHIFT_ARBITER_ROR_EN
        ror_op("ror 8", 5'd8, 32'h12345678, 32'h78123456);
        ror_op("ror 0", 5'd0, 32'h12345678, 32'h12345678);
        ror_op("ror 1", 5'd1, 32'h80000001, 32'hC0000000);
`else
        single_op("op11 as srl", 0, ROR, 5'd8, 32'h12345678, 32'h00123456);
`endif

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rr_stream();
        stall_test();
        reset_in_done();
`ifdef SHIFT_ARBITER_ROR_EN
        reset_in_pass2();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
